// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   ADDR_W         : instruction word-address width (64-word store)
//   DATA_W         : instruction width, four bytes
//   loader_state_t : loader FSM states
package imem_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// Big-endian byte-to-word packer for the instruction loader.
// The first byte strobed after a clear ends up in the top byte of the word.
// Ports:
//   clk       : system clock
//   clear     : synchronous clear of the byte index and the word register
//   strobe    : shift octet into the word this cycle
//   octet     : incoming byte
//   word      : assembled word (holds its value between strobes)
//   word_full : byte index is 3, so the next strobed byte completes the word
module word_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              strobe,
  input  logic [7:0]        octet,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);
  import imem_pkg::*;

  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (clear) begin
      idx  <= 2'd0;
      word <= '0;
    end else if (strobe) begin
      idx  <= idx + 2'd1;
      word <= {word[DATA_W-9:0], octet};
    end
  end

  assign word_full = (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time writer for the MIPS instruction RAM. Receives a byte stream
// under valid/ready, packs bytes big-endian into words and writes them to
// consecutive word addresses while holding the processor in reset.
// Optional feature macro: IMEM_LOADER_CKSUM_EN -- the in_last byte is an
// XOR checksum of all earlier bytes of the load instead of data.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin a load (honoured in IDLE or DONE only)
//   in_data/in_valid/in_last/in_ready : byte stream handshake
//   we/waddr/wdata   : instruction-RAM write port
//   cpu_hold, busy   : high while receiving or writing
//   done, err        : load finished / load had an error
//   word_count       : words written by the last load
module imem_loader #(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int DATA_W = imem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  import imem_pkg::*;

  // word_count value at which the store is full
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     state, state_nxt;
  logic              start_ok, accept, at_cap;
  logic              pk_clear, pk_stb, pk_full;
  logic [DATA_W-1:0] pk_word;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W:0]   wc_q;
  logic              err_q;
  logic              last_q;   // the word now being written ended the stream
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        xor_q;     // running XOR of accepted data bytes
  logic              pending_q; // a partial word is sitting in the packer
`endif

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign accept   = in_valid && in_ready;
  assign at_cap   = (wc_q == CAP);
  assign pk_clear = reset || start_ok;

  word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .clear     (pk_clear),
    .strobe    (pk_stb),
    .octet     (in_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_nxt = state;
    pk_stb    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RECV;
      RECV: begin
        if (accept) begin
          // A byte arriving with the store already full is dropped.
          if (at_cap) begin
            state_nxt = DONE;
`ifdef IMEM_LOADER_CKSUM_EN
          end else if (in_last) begin
            // Checksum byte: never packed, never written.
            state_nxt = DONE;
`endif
          end else begin
            pk_stb = 1'b1;
            if (pk_full)      state_nxt = WRITE;
            else if (in_last) state_nxt = DONE;
          end
        end
      end
      WRITE: state_nxt = last_q ? DONE : RECV;
      DONE:  if (start) state_nxt = RECV;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      waddr_q   <= '0;
      wc_q      <= '0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      xor_q     <= 8'd0;
      pending_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        wc_q      <= '0;
        err_q     <= 1'b0;
        last_q    <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
        xor_q     <= 8'd0;
        pending_q <= 1'b0;
`endif
      end
      if ((state == RECV) && accept) begin
        if (at_cap) begin
          err_q <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
        end else if (in_last) begin
          if ((in_data != xor_q) || pending_q) err_q <= 1'b1;
        end else begin
          xor_q     <= xor_q ^ in_data;
          pending_q <= !pk_full;
          if (pk_full) waddr_q <= wc_q[ADDR_W-1:0];
        end
`else
        end else if (pk_full) begin
          waddr_q <= wc_q[ADDR_W-1:0];
          last_q  <= in_last;
        end else if (in_last) begin
          // stream ended mid-word; the partial word is not written
          err_q <= 1'b1;
        end
`endif
      end
      if (state == WRITE) wc_q <= wc_q + (ADDR_W+1)'(1);
    end
  end

  assign in_ready   = (state == RECV);
  assign we         = (state == WRITE);
  assign busy       = (state == RECV) || (state == WRITE);
  assign cpu_hold   = busy;
  assign done       = (state == DONE);
  assign err        = err_q;
  assign waddr      = waddr_q;
  assign wdata      = pk_word;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: each load's expected RAM writes and
// final status come from a stream-level model; a monitor pops and compares
// every write the loader issues.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW  = imem_pkg::ADDR_W;
  localparam int DW  = imem_pkg::DATA_W;
  localparam int CAP = 1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last;
  logic [7:0]    in_data;
  logic          in_ready, we, cpu_hold, busy, done, err;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW:0]   word_count;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  int   exp_wc;
  logic exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready_only_in_recv", in_ready, busy && !we);
      check("cpu_hold_tracks_busy", cpu_hold, busy);
      if (we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("waddr", waddr, mon_e.addr);
          check("wdata", wdata, mon_e.data);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_waddr"}, waddr, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_word_count"}, word_count, 0);
  endtask

  // Stream-level model: whole words written, capacity limit, error rules.
  task automatic load_model(input bq_t q, input int stop);
    int  n;
    int  nw;
    wr_t e;
    n = q.size();
    if (stop >= 0) begin
      nw = stop / 4;
      exp_err = 1'b0;
    end else if (n > 4 * CAP) begin
      nw = CAP;
      exp_err = 1'b1;
    end else begin
`ifdef IMEM_LOADER_CKSUM_EN
      begin
        int d;
        logic [7:0] x;
        d = n - 1;
        x = 8'd0;
        for (int k = 0; k < d; k++) x ^= q[k];
        nw = d / 4;
        exp_err = ((d % 4) != 0) || (q[n-1] != x);
      end
`else
      nw = n / 4;
      exp_err = ((n % 4) != 0);
`endif
    end
    exp_wc = nw;
    for (int w = 0; w < nw; w++) begin
      e.addr = AW'(w);
      e.data = {q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]};
      exp_q.push_back(e);
    end
  endtask

  // mode 0: continuous, 1: in_valid every other cycle, 2: random gaps
  // stop >= 0: quit after that many accepted bytes (caller then resets)
  task automatic run_load(input bq_t q, input int mode, input int stop);
    int n, i, cyc, lim;
    bit gap, acc, is_data;
    n = q.size();
    i = 0;
    cyc = 0;
    lim = (stop >= 0) ? stop : n;
    load_model(q, stop);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("cpu_hold_after_start", cpu_hold, 1);
    check("done_after_start", done, 0);
    while (i < lim && cyc < 4000 && !done) begin
      case (mode)
        0:       gap = 1'b0;
        1:       gap = ((cyc % 2) == 1);
        default: gap = ($urandom_range(0, 3) == 0);
      endcase
      in_valid = !gap;
      in_data  = gap ? 8'($urandom) : q[i];
      in_last  = !gap && (i == n - 1);
      start    = gap && (mode == 2) && ($urandom_range(0, 7) == 0);
`ifdef IMEM_LOADER_CKSUM_EN
      is_data = (i != n - 1);
`else
      is_data = 1'b1;
`endif
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc && is_data && ((i % 4) == 3) && (i < 4 * CAP)) begin
        check("we_latency", we, 1);
        check("in_ready_in_write", in_ready, 0);
      end
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'd0;
    start    = 1'b0;
    if (stop >= 0) return;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done", done, 1);
    check("err", err, exp_err);
    check("word_count", word_count, exp_wc);
    check("busy_at_done", busy, 0);
    check("cpu_hold_at_done", cpu_hold, 0);
    check("writes_outstanding", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("done_holds", done, 1);
    check("word_count_holds", word_count, exp_wc);
    exp_q.delete();
  endtask

  task automatic make_stream(input int n, output bq_t q);
    q = {};
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
`ifdef IMEM_LOADER_CKSUM_EN
    begin
      logic [7:0] x;
      x = 8'd0;
      for (int k = 0; k < n - 1; k++) x ^= q[k];
      if ($urandom_range(0, 3) != 0) q[n-1] = x;
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t q;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    // two-word program, continuous and with in_valid toggling
    q = '{8'h20, 8'h14, 8'hFF, 8'hF6, 8'h20, 8'h09, 8'h00, 8'h07};
    run_load(q, 0, -1);
    run_load(q, 1, -1);

    // stream ending mid-word
    q = '{8'h20, 8'h14, 8'hFF, 8'hF6, 8'h20, 8'h09};
    run_load(q, 0, -1);

    // capacity: 257 bytes overflow, 256 bytes fill exactly
    make_stream(257, q);
    run_load(q, 0, -1);
    make_stream(256, q);
    run_load(q, 2, -1);

    // reset after 5 bytes aborts the load
    make_stream(12, q);
    run_load(q, 0, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    check("abort_writes_seen", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    make_stream(4, q);
    run_load(q, 0, -1);

`ifdef IMEM_LOADER_CKSUM_EN
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_load(q, 0, -1);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(q, 0, -1);
`endif

    for (int t = 0; t < 12; t++) begin
      make_stream($urandom_range(1, 40), q);
      run_load(q, $urandom_range(0, 2), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
